// File: rtl/abfsm_pkg.sv
// Shared types for the shared-detector arbiter: detector and controller
// state encodings plus the detector next-state function.
package abfsm_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN   = 2'b01,
    FLUSH = 2'b10
  } ctl_state_e;

  function automatic det_state_e det_next(
    det_state_e s,
    logic       a,
    logic       b
  );
    det_state_e n;
    n = S0;
    unique case (s)
      S0: begin
        if (a & b) n = S2;
        else if (a) n = S1;
        else n = S0;
      end
      S1:      n = a ? S0 : S1;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/abfsm_share_arb_rr_pick.sv
// Round-robin picker: first set request searching upward from last+1,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  win_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] c;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = '0;
    for (int i = 1; i <= N; i++) begin
      c = IW'((32'(last_i) + 32'(i)) % 32'(N));
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = c;
        win_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abfsm_share_arb.sv
// Round-robin owner of one shared a/b detector; keeps a shadow of the
// detector state so grants are only released with the detector in S0.
module abfsm_share_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] a_req,
  input  logic [N-1:0] b_req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] hit,
  output logic         fsm_a,
  output logic         fsm_b,
  input  logic         fsm_y0,
  input  logic         fsm_y1,
  output logic         busy,
  output logic         err
);

  import abfsm_pkg::*;

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  ctl_state_e    state_q, state_d;
  det_state_e    shd_q, shd_d;
  logic [IW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          err_q, err_d;

  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic          own_req;
  logic          others;
  logic          rel;
  logic          exp_y1;
  logic          exp_y0;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win),
    .idx_o  (win_idx),
    .any_o  (win_any)
  );

  // In OWN the owner is always the last winner.
  assign own_req = req[last_q];
  assign others  = |(req & ~gnt_q);

  always_comb begin
    fsm_a = 1'b0;
    fsm_b = 1'b0;
    hit   = '0;
    unique case (state_q)
      OWN: begin
        if (own_req) begin
          fsm_a       = a_req[last_q];
          fsm_b       = b_req[last_q];
          hit[last_q] = fsm_y0;
        end
      end
      FLUSH: fsm_a = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    rel     = 1'b0;
    shd_d   = det_next(shd_q, fsm_a, fsm_b);
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = OWN;
          gnt_d   = win;
          last_d  = win_idx;
          hold_d  = '0;
        end
      end
      OWN: begin
        rel = !own_req || ((hold_q == HOLD_MAX) && others);
        // Saturate so a lone owner is preempted as soon as anyone asks.
        if (own_req && (hold_q != HOLD_MAX))
          hold_d = hold_q + HW'(1);
        if (rel) begin
          gnt_d   = '0;
          state_d = (shd_d == S0) ? IDLE : FLUSH;
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign exp_y1 = (shd_q == S0) || (shd_q == S1);
  assign exp_y0 = (shd_q == S0) & fsm_a & fsm_b;
  assign err_d  = err_q | (fsm_y1 != exp_y1) | (fsm_y0 != exp_y0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shd_q   <= S0;
      last_q  <= IW'(N - 1);
      hold_q  <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shd_q   <= shd_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_abfsm_share_arb.sv
// Directed bench for abfsm_share_arb with a behavioural detector
// that can be forced to misbehave.
module tb_abfsm_share_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, a_req, b_req;
  logic [3:0] gnt, hit;
  logic       fsm_a, fsm_b, fsm_y0, fsm_y1;
  logic       busy, err;

  logic [1:0] det_q;
  logic       force_y1;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  abfsm_share_arb #(.N(4), .MAX_HOLD(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_req  (a_req),
    .b_req  (b_req),
    .gnt    (gnt),
    .hit    (hit),
    .fsm_a  (fsm_a),
    .fsm_b  (fsm_b),
    .fsm_y0 (fsm_y0),
    .fsm_y1 (fsm_y1),
    .busy   (busy),
    .err    (err)
  );

  always @(posedge clk or posedge reset)
    if (reset) det_q <= 2'b00;
    else case (det_q)
      2'b00:   det_q <= (fsm_a & fsm_b) ? 2'b10 : (fsm_a ? 2'b01 : 2'b00);
      2'b01:   det_q <= fsm_a ? 2'b00 : 2'b01;
      default: det_q <= 2'b00;
    endcase

  assign fsm_y1 = (det_q != 2'b10) & ~force_y1;
  assign fsm_y0 = (det_q == 2'b00) & fsm_a & fsm_b;

  typedef struct {
    logic [3:0] req, a, b;
    logic [3:0] g, h;
    logic       fa, fb, bz;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [11:0] ex(logic [3:0] g, logic [3:0] h,
                                     logic fa, logic fb,
                                     logic bz, logic er);
    return {g, h, fa, fb, bz, er};
  endfunction

  task automatic check(string nm, logic [11:0] e);
    logic [11:0] got;
    got = {gnt, hit, fsm_a, fsm_b, busy, err};
    nvec++;
    if (got !== e) begin
      nmis++;
      $display("FAIL %s: got gnt/hit/a/b/busy/err=%b_%b_%b%b%b%b exp %b_%b_%b%b%b%b",
               nm, got[11:8], got[7:4], got[3], got[2], got[1], got[0],
               e[11:8], e[7:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  function automatic vec_t mk(logic [3:0] r, logic [3:0] a, logic [3:0] b,
                              logic [3:0] g, logic [3:0] h,
                              logic fa, logic fb, logic bz);
    vec_t v;
    v.req = r; v.a = a; v.b = b;
    v.g = g; v.h = h; v.fa = fa; v.fb = fb; v.bz = bz;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 1, 1);
    tbl[1]  = mk(4'b1110, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 0, 0, 1);
    tbl[2]  = mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(4'b1110, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 0, 1);
    tbl[4]  = mk(4'b1100, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, 0, 1);
    tbl[5]  = mk(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1);
    tbl[6]  = mk(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[7]  = mk(4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 1, 1);
    tbl[8]  = mk(4'b1100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 0, 1);
    tbl[9]  = mk(4'b1100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 0, 1);
    tbl[10] = mk(4'b1100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1, 0, 1);
    tbl[11] = mk(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1);
    tbl[12] = mk(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[13] = mk(4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1, 1, 1);

    reset = 1'b1; force_y1 = 1'b0;
    req = 4'b1111; a_req = '0; b_req = '0;
    @(negedge clk);
    check("reset", ex(4'b0000, 4'b0000, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      req = tbl[i].req; a_req = tbl[i].a; b_req = tbl[i].b;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            ex(tbl[i].g, tbl[i].h, tbl[i].fa, tbl[i].fb, tbl[i].bz, 1'b0));
    end

    reset = 1'b1;
    #1;
    check("rst_mid_own", ex(4'b0000, 4'b0000, 0, 0, 0, 0));

    req = 4'b1111; a_req = '0; b_req = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      logic [3:0] eg;
      int pos;
      pos = k % 5;
      eg  = (pos < 4) ? 4'(1 << ((k / 5) % 4)) : 4'b0000;
      @(negedge clk);
      check($sformatf("rot%0d", k), ex(eg, 4'b0000, 0, 0, pos < 4, 0));
    end

    reset = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("lone%0d", k), ex(4'b0100, 4'b0000, 0, 0, 1, 0));
    end
    req = 4'b0101;
    @(negedge clk);
    check("lone_preempt", ex(4'b0000, 4'b0000, 0, 0, 0, 0));
    @(negedge clk);
    check("lone_next", ex(4'b0001, 4'b0000, 0, 0, 1, 0));

    reset = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("err_clear", ex(4'b0000, 4'b0000, 0, 0, 0, 0));
    force_y1 = 1'b1;
    @(negedge clk);
    force_y1 = 1'b0;
    check("err_set", ex(4'b0000, 4'b0000, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("err_sticky%0d", k), ex(4'b0000, 4'b0000, 0, 0, 0, 1));
    end
    reset = 1'b1;
    #1;
    check("err_reset", ex(4'b0000, 4'b0000, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
